// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and default control words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } fetchState_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: register jump, direct jump, taken branch, then sequential.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is loaded.
module pc_next_sel (
   input  logic [31:0] pc,
   input  logic        jumpReg,
   input  logic        jump,
   input  logic        branchTaken,
   input  logic [31:0] regTarget,
   input  logic [31:0] branchOffset,
   input  logic [31:0] pcPlus4Id,
   input  logic [25:0] jumpIndex,
   output logic [31:0] nextPc
);

   always_comb begin
      if (jumpReg)
         nextPc = regTarget;
      else if (jump)
         nextPc = {pcPlus4Id[31:28], jumpIndex, 2'b00};
      else if (branchTaken)
         nextPc = pcPlus4Id + (branchOffset << 2);
      else
         nextPc = pc + 32'd4;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect/squash and halt-drain FSM.
// Latency: imemAddr is the registered PC; a redirect lands on the next edge.
// Backpressure: stall freezes PC and IF/ID writes, outranking any redirect.
module fetch_unit import pipeline_pkg::*; #(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic        jump,
   input  logic        jumpReg,
   input  logic [31:0] branchOffset,
   input  logic [25:0] jumpIndex,
   input  logic [31:0] regTarget,
   input  logic [31:0] pcPlus4Id,
   input  logic [31:0] imemData,
   output logic [31:0] imemAddr,
   output logic [31:0] pcPlus4,
   output logic [31:0] preInstruction,
   output logic        branch,
   output logic        ifIdWrIn,
   output logic        endProgram
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   fetchState_t      state;
   logic [31:0]      pc;
   logic [31:0]      nextPc;
   logic [CNT_W-1:0] drainCnt;
   logic             running;
   logic             redirect;
   logic             haltSeen;

   assign running  = (state == RUN);
   assign redirect = running & (jumpReg | jump | branchTaken) & ~stall;
   // A halt word only counts when it would actually enter IF/ID.
   assign haltSeen = running & ~stall & ~redirect & (imemData == HALT_WORD);

   assign imemAddr       = pc;
   assign pcPlus4        = pc + 32'd4;
   assign branch         = redirect;
   assign preInstruction = running ? imemData : 32'd0;
   assign ifIdWrIn       = running ? ~stall : (state == DRAIN);

   pc_next_sel u_pcNextSel (
      .pc           (pc),
      .jumpReg      (jumpReg),
      .jump         (jump),
      .branchTaken  (branchTaken),
      .regTarget    (regTarget),
      .branchOffset (branchOffset),
      .pcPlus4Id    (pcPlus4Id),
      .jumpIndex    (jumpIndex),
      .nextPc       (nextPc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= RESET_PC;
         state      <= RUN;
         drainCnt   <= '0;
         endProgram <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (haltSeen) begin
                  state    <= DRAIN;
                  drainCnt <= CNT_W'(DRAIN_CYCLES - 1);
               end else if (!stall) begin
                  pc <= nextPc;
               end
            end
            DRAIN: begin
               // Nops keep flowing into IF/ID so older instructions retire.
               if (drainCnt == '0) begin
                  state      <= DONE;
                  endProgram <= 1'b1;
               end else begin
                  drainCnt <= drainCnt - CNT_W'(1);
               end
            end
            DONE: endProgram <= 1'b1;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized run against a cycle model.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
   localparam int          DRAIN_N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branchTaken, jump, jumpReg;
   logic [31:0] branchOffset, regTarget, pcPlus4Id, imemData;
   logic [25:0] jumpIndex;
   logic [31:0] imemAddr, pcPlus4, preInstruction;
   logic        branch, ifIdWrIn, endProgram;

   logic        haltEn;
   logic [31:0] haltAddr;
   int          errors = 0;
   int          checks = 0;

   // Reference model state: PC, remaining drain cycles (-1 when not draining), finished flag.
   logic [31:0] mPc;
   int          mDrain;
   logic        mDone;

   fetch_unit #(.RESET_PC(RST_PC), .HALT_WORD(HALT), .DRAIN_CYCLES(DRAIN_N)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branchTaken    (branchTaken),
      .jump           (jump),
      .jumpReg        (jumpReg),
      .branchOffset   (branchOffset),
      .jumpIndex      (jumpIndex),
      .regTarget      (regTarget),
      .pcPlus4Id      (pcPlus4Id),
      .imemData       (imemData),
      .imemAddr       (imemAddr),
      .pcPlus4        (pcPlus4),
      .preInstruction (preInstruction),
      .branch         (branch),
      .ifIdWrIn       (ifIdWrIn),
      .endProgram     (endProgram)
   );

   always #5 clk = ~clk;

   // Instruction memory: address-derived words, with one optional halt location.
   function automatic logic [31:0] memWord(input logic [31:0] a, input logic en, input logic [31:0] h);
      return (en && a == h) ? HALT : (a ^ 32'h5A5A_0000);
   endfunction

   always_comb imemData = memWord(imemAddr, haltEn, haltAddr);

   task automatic idleInputs();
      stall = 1'b0; branchTaken = 1'b0; jump = 1'b0; jumpReg = 1'b0;
      branchOffset = 32'd0; jumpIndex = 26'd0; regTarget = 32'd0; pcPlus4Id = 32'd0;
   endtask

   task automatic pulseReset();
      @(negedge clk); reset = 1'b0; #1;
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_reset();
      idleInputs(); haltEn = 1'b0; haltAddr = 32'd0;
      reset = 1'b0; #2;
      checks++; if (imemAddr !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", imemAddr, RST_PC); end
      checks++; if (pcPlus4 !== RST_PC + 32'd4) begin errors++; $display("FAIL reset_pcplus4: got %h want %h", pcPlus4, RST_PC + 32'd4); end
      checks++; if (endProgram !== 1'b0) begin errors++; $display("FAIL reset_end: got %b want 0", endProgram); end
      checks++; if (branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b want 0", branch); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (imemAddr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imemAddr, 32'(i * 4)); end
         checks++; if (pcPlus4 !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pcplus4[%0d]: got %h want %h", i, pcPlus4, 32'(i * 4 + 4)); end
         checks++; if (preInstruction !== (32'(i * 4) ^ 32'h5A5A_0000) || ifIdWrIn !== 1'b1) begin
            errors++; $display("FAIL seq_ifid[%0d]: got %h/%b want %h/1", i, preInstruction, ifIdWrIn, 32'(i * 4) ^ 32'h5A5A_0000);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);  // PC now 0x14
      branchTaken = 1'b1; pcPlus4Id = 32'h20; branchOffset = 32'hFFFF_FFFC; #1;
      checks++; if (branch !== 1'b1 || imemAddr !== 32'h14) begin errors++; $display("FAIL br_assert: got branch=%b addr=%h want 1/00000014", branch, imemAddr); end
      @(negedge clk); idleInputs(); #1;
      checks++; if (imemAddr !== 32'h10) begin errors++; $display("FAIL br_target: got %h want 00000010", imemAddr); end
      checks++; if (branch !== 1'b0) begin errors++; $display("FAIL br_oneshot: got %b want 0", branch); end
      @(negedge clk); #1;
      checks++; if (imemAddr !== 32'h14) begin errors++; $display("FAIL br_resume: got %h want 00000014", imemAddr); end
   endtask

   task automatic test_stall_jumpreg();
      stall = 1'b1; jumpReg = 1'b1; regTarget = 32'h100;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (imemAddr !== 32'h14) begin errors++; $display("FAIL stall_hold[%0d]: got %h want 00000014", i, imemAddr); end
         checks++; if (ifIdWrIn !== 1'b0 || branch !== 1'b0) begin errors++; $display("FAIL stall_ctrl[%0d]: got wr=%b br=%b want 0/0", i, ifIdWrIn, branch); end
         @(negedge clk);
      end
      stall = 1'b0; #1;
      checks++; if (branch !== 1'b1) begin errors++; $display("FAIL stall_release_br: got %b want 1", branch); end
      @(negedge clk); idleInputs(); #1;
      checks++; if (imemAddr !== 32'h100) begin errors++; $display("FAIL stall_jr_target: got %h want 00000100", imemAddr); end
   endtask

   task automatic test_halt();
      haltEn = 1'b1; haltAddr = 32'h40;
      @(negedge clk); jumpReg = 1'b1; regTarget = 32'h40;
      @(negedge clk); idleInputs(); #1;
      checks++; if (imemAddr !== 32'h40 || preInstruction !== HALT) begin errors++; $display("FAIL halt_fetch: got %h/%h want 00000040/%h", imemAddr, preInstruction, HALT); end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         jump = 1'b1; jumpIndex = 26'h3F; branchTaken = 1'b1; #1;
         checks++; if (imemAddr !== 32'h40 || pcPlus4 !== 32'h44) begin errors++; $display("FAIL halt_pc[%0d]: got %h want 00000040", k, imemAddr); end
         checks++; if (branch !== 1'b0 || preInstruction !== 32'd0) begin errors++; $display("FAIL halt_nop[%0d]: got br=%b pre=%h want 0/0", k, branch, preInstruction); end
         checks++; if (endProgram !== (k >= 5)) begin errors++; $display("FAIL halt_end[%0d]: got %b want %b", k, endProgram, k >= 5); end
         checks++; if (ifIdWrIn !== (k <= 4)) begin errors++; $display("FAIL halt_wr[%0d]: got %b want %b", k, ifIdWrIn, k <= 4); end
      end
      idleInputs();
   endtask

   task automatic test_squashed_halt();
      haltAddr = 32'h8;
      pulseReset(); #1;
      checks++; if (imemAddr !== RST_PC || endProgram !== 1'b0) begin errors++; $display("FAIL done_reset: got %h/%b want %h/0", imemAddr, endProgram, RST_PC); end
      @(negedge clk); @(negedge clk);
      stall = 1'b1; #1;
      checks++; if (imemAddr !== 32'h8 || ifIdWrIn !== 1'b0) begin errors++; $display("FAIL sq_stall: got %h/%b want 00000008/0", imemAddr, ifIdWrIn); end
      @(negedge clk);
      stall = 1'b0; jump = 1'b1; jumpIndex = 26'h40; pcPlus4Id = 32'h3000_0000; #1;
      checks++; if (imemAddr !== 32'h8 || branch !== 1'b1) begin errors++; $display("FAIL sq_hold: got %h/%b want 00000008/1", imemAddr, branch); end
      @(negedge clk); idleInputs(); #1;
      checks++; if (imemAddr !== 32'h3000_0100) begin errors++; $display("FAIL sq_jump: got %h want 30000100", imemAddr); end
      checks++; if (endProgram !== 1'b0 || ifIdWrIn !== 1'b1 || preInstruction !== 32'h6A5A_0100) begin
         errors++; $display("FAIL sq_run: got end=%b wr=%b pre=%h want 0/1/6a5a0100", endProgram, ifIdWrIn, preInstruction);
      end
      @(negedge clk); #1;
      checks++; if (imemAddr !== 32'h3000_0104) begin errors++; $display("FAIL sq_seq: got %h want 30000104", imemAddr); end
   endtask

   task automatic test_reset_drain();
      pulseReset();
      @(negedge clk); @(negedge clk);  // at 0x8, halt enters
      @(negedge clk); @(negedge clk);  // two cycles into drain
      #1;
      checks++; if (imemAddr !== 32'h8 || preInstruction !== 32'd0 || ifIdWrIn !== 1'b1) begin
         errors++; $display("FAIL rd_draining: got %h/%h/%b want 00000008/0/1", imemAddr, preInstruction, ifIdWrIn);
      end
      #1; reset = 1'b0; #1;
      checks++; if (imemAddr !== RST_PC || endProgram !== 1'b0) begin errors++; $display("FAIL rd_async: got %h/%b want %h/0", imemAddr, endProgram, RST_PC); end
      checks++; if (preInstruction !== 32'h5A5A_0000) begin errors++; $display("FAIL rd_run: got %h want 5a5a0000", preInstruction); end
      @(negedge clk); reset = 1'b1; #1;
      checks++; if (imemAddr !== RST_PC) begin errors++; $display("FAIL rd_release: got %h want %h", imemAddr, RST_PC); end
      @(negedge clk); #1;
      checks++; if (imemAddr !== 32'h4) begin errors++; $display("FAIL rd_resume: got %h want 00000004", imemAddr); end
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic modelStep();
      if (!mDone && mDrain < 0 && !stall) begin
         if (jumpReg)           mPc = regTarget;
         else if (jump)         mPc = {pcPlus4Id[31:28], jumpIndex, 2'b00};
         else if (branchTaken)  mPc = pcPlus4Id + branchOffset * 32'd4;
         else if (memWord(mPc, haltEn, haltAddr) == HALT) mDrain = DRAIN_N;
         else                   mPc = mPc + 32'd4;
      end else if (mDrain >= 0) begin
         mDrain--;
         if (mDrain == 0) begin mDone = 1'b1; mDrain = -1; end
      end
   endtask

   task automatic test_random();
      logic        running;
      logic [31:0] expPre;
      haltEn = 1'b1; haltAddr = 32'($urandom_range(0, 63)) << 2;
      idleInputs(); pulseReset();
      mPc = RST_PC; mDrain = -1; mDone = 1'b0;
      for (int n = 0; n < 800; n++) begin
         if (n > 0) @(negedge clk);
         if ((mDone && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
            reset = 1'b0; #1;
            checks++; if (imemAddr !== RST_PC || endProgram !== 1'b0) begin errors++; $display("FAIL rnd_reset[%0d]: got %h/%b want %h/0", n, imemAddr, endProgram, RST_PC); end
            mPc = RST_PC; mDrain = -1; mDone = 1'b0;
            haltAddr = 32'($urandom_range(0, 63)) << 2;
            @(negedge clk); reset = 1'b1;
         end
         stall        = ($urandom_range(0, 3) == 0);
         jumpReg      = ($urandom_range(0, 9) == 0);
         jump         = ($urandom_range(0, 9) == 0);
         branchTaken  = ($urandom_range(0, 9) == 0);
         regTarget    = 32'($urandom_range(0, 63)) << 2;
         jumpIndex    = 26'($urandom_range(0, 63));
         pcPlus4Id    = 32'($urandom_range(0, 63)) << 2;
         branchOffset = 32'($urandom_range(0, 31)) - 32'd16;
         #1;
         running = !mDone && mDrain < 0;
         expPre  = running ? memWord(mPc, haltEn, haltAddr) : 32'd0;
         checks++; if (imemAddr !== mPc || pcPlus4 !== mPc + 32'd4) begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h", n, imemAddr, pcPlus4, mPc); end
         checks++; if (branch !== (running && !stall && (jumpReg || jump || branchTaken))) begin
            errors++; $display("FAIL rnd_branch[%0d]: got %b want %b", n, branch, running && !stall && (jumpReg || jump || branchTaken));
         end
         checks++; if (ifIdWrIn !== (running ? !stall : (mDrain >= 0))) begin
            errors++; $display("FAIL rnd_wr[%0d]: got %b want %b", n, ifIdWrIn, running ? !stall : (mDrain >= 0));
         end
         checks++; if (preInstruction !== expPre) begin errors++; $display("FAIL rnd_pre[%0d]: got %h want %h", n, preInstruction, expPre); end
         checks++; if (endProgram !== mDone) begin errors++; $display("FAIL rnd_end[%0d]: got %b want %b", n, endProgram, mDone); end
         modelStep();
      end
      idleInputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall_jumpreg();
      test_halt();
      test_squashed_halt();
      test_reset_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
